imem_port_arbiter: RTL and testbench

- Shares one single-ported, synchronous-read instruction RAM between two requesters: the core fetch stage and the program loader/debug port.
- The loader can read and write. Fetch is read-only.
- Sits between the fetch stage, the loader, and the instruction RAM macro. Presents a 32-bit byte-address valid/ready request interface and a 1-cycle-latency response to each requester.
- Arbitration is loader-priority with a starvation guard for fetch.

---
 rtl/imem_port_arbiter_if.sv | 45 ++++
 rtl/imem_port_arbiter.sv | 90 +++++++++
 tb/tb_imem_port_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the loader port, the instruction RAM and the arbiter.
// The arbiter takes the slave view. The environment (requesters plus RAM) takes the master view.
interface imem_port_arbiter_if #(
  parameter int AW = 10
);
  logic          f_req_valid;
  logic          f_req_ready;
  logic [31:0]   f_req_addr;
  logic          f_rsp_valid;
  logic [31:0]   f_rsp_data;
  logic          f_rsp_err;

  logic          l_req_valid;
  logic          l_req_ready;
  logic          l_req_we;
  logic [31:0]   l_req_addr;
  logic [31:0]   l_req_wdata;
  logic          l_rsp_valid;
  logic [31:0]   l_rsp_data;
  logic          l_rsp_err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  f_req_valid, f_req_addr,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  l_req_valid, l_req_we, l_req_addr, l_req_wdata,
    output l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output f_req_valid, f_req_addr,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output l_req_valid, l_req_we, l_req_addr, l_req_wdata,
    input  l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a single-ported sync-read instruction RAM between fetch (read-only) and the loader.
// The loader has priority, and a burst counter guarantees that fetch is served after MAX_LDR_BURST loader grants.
module imem_port_arbiter #(
  parameter int MEM_DEPTH     = 1024,
  parameter int AW            = 10,
  parameter int MAX_LDR_BURST = 4
) (
  input logic                clk,
  input logic                rst,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_LOADER
  } owner_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_LDR_BURST);

  owner_t      owner, owner_nxt;
  logic        rsp_err, rsp_err_nxt;
  logic        rsp_wr, rsp_wr_nxt;
  logic [3:0]  starv_cnt, starv_cnt_nxt;
  logic        grant_f, grant_l;
  logic [31:0] gnt_addr;
  logic        addr_err;

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(MEM_DEPTH));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_NONE;
      rsp_err   <= 1'b0;
      rsp_wr    <= 1'b0;
      starv_cnt <= '0;
    end else begin
      owner     <= owner_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_wr    <= rsp_wr_nxt;
      starv_cnt <= starv_cnt_nxt;
    end
  end

  always_comb begin
    grant_l       = bus.l_req_valid && (!bus.f_req_valid || (starv_cnt < MAX_CNT));
    grant_f       = bus.f_req_valid && !grant_l;
    gnt_addr      = grant_l ? bus.l_req_addr : bus.f_req_addr;
    addr_err      = bad_addr(gnt_addr);

    bus.f_req_ready = grant_f;
    bus.l_req_ready = grant_l;
    bus.mem_en      = (grant_l || grant_f) && !addr_err;
    bus.mem_we      = bus.mem_en && grant_l && bus.l_req_we;
    bus.mem_addr    = bus.mem_en ? gnt_addr[AW+1:2] : '0;
    bus.mem_wdata   = (bus.mem_en && grant_l) ? bus.l_req_wdata : '0;

    owner_nxt   = OWN_NONE;
    rsp_err_nxt = 1'b0;
    rsp_wr_nxt  = 1'b0;
    if (grant_l) begin
      owner_nxt   = OWN_LOADER;
      rsp_err_nxt = addr_err;
      rsp_wr_nxt  = bus.l_req_we;
    end else if (grant_f) begin
      owner_nxt   = OWN_FETCH;
      rsp_err_nxt = addr_err;
    end

    // The counter only tracks loader grants that occur while fetch is actually waiting.
    starv_cnt_nxt = starv_cnt;
    if (!bus.f_req_valid || grant_f) begin
      starv_cnt_nxt = '0;
    end else if (grant_l && (starv_cnt < MAX_CNT)) begin
      starv_cnt_nxt = starv_cnt + 4'd1;
    end
  end

  always_comb begin
    bus.f_rsp_valid = (owner == OWN_FETCH);
    bus.f_rsp_err   = (owner == OWN_FETCH) && rsp_err;
    bus.f_rsp_data  = ((owner == OWN_FETCH) && !rsp_err) ? bus.mem_rdata : '0;
    bus.l_rsp_valid = (owner == OWN_LOADER);
    bus.l_rsp_err   = (owner == OWN_LOADER) && rsp_err;
    bus.l_rsp_data  = ((owner == OWN_LOADER) && !rsp_err && !rsp_wr) ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural synchronous-read RAM attached.
// The bench loads the RAM through the loader port before fetch reads it back.
module tb_imem_port_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  imem_port_arbiter_if #(.AW(10)) bus ();

  imem_port_arbiter #(
    .MEM_DEPTH    (1024),
    .AW           (10),
    .MAX_LDR_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [31:0] ram [0:1023];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : ram[bus.mem_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic fv, input logic [31:0] fa, input logic lv,
                               input logic lwe, input logic [31:0] la, input logic [31:0] lwd);
    @(negedge clk);
    bus.f_req_valid = fv;
    bus.f_req_addr  = fa;
    bus.l_req_valid = lv;
    bus.l_req_we    = lwe;
    bus.l_req_addr  = la;
    bus.l_req_wdata = lwd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " f_rsp_valid"}, 32'(bus.f_rsp_valid), 32'd0);
    checkOutput({tag, " l_rsp_valid"}, 32'(bus.l_rsp_valid), 32'd0);
    checkOutput({tag, " f_rsp_err"},   32'(bus.f_rsp_err),   32'd0);
    checkOutput({tag, " l_rsp_err"},   32'(bus.l_rsp_err),   32'd0);
    checkOutput({tag, " f_rsp_data"},  bus.f_rsp_data,       32'd0);
    checkOutput({tag, " l_rsp_data"},  bus.l_rsp_data,       32'd0);
    checkOutput({tag, " mem_en"},      32'(bus.mem_en),      32'd0);
    checkOutput({tag, " f_req_ready"}, 32'(bus.f_req_ready), 32'd0);
    checkOutput({tag, " l_req_ready"}, 32'(bus.l_req_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] prog [0:2];
    logic        exp_l;
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.f_req_valid = 1'b0;
    bus.f_req_addr  = '0;
    bus.l_req_valid = 1'b0;
    bus.l_req_we    = 1'b0;
    bus.l_req_addr  = '0;
    bus.l_req_wdata = '0;
    bus.mem_rdata   = '0;

    #12;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load the first three program words through the loader port.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'(i * 4), prog[i]);
      checkOutput("preload l_req_ready", 32'(bus.l_req_ready), 32'd1);
      checkOutput("preload mem_we", 32'(bus.mem_we), 32'd1);
      tick();
      checkOutput("preload l_rsp_valid", 32'(bus.l_rsp_valid), 32'd1);
      checkOutput("preload l_rsp_data", bus.l_rsp_data, 32'd0);
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'd0, 32'd0);
      checkOutput("fetch f_req_ready", 32'(bus.f_req_ready), 32'd1);
      checkOutput("fetch l_req_ready", 32'(bus.l_req_ready), 32'd0);
      checkOutput("fetch mem_en", 32'(bus.mem_en), 32'd1);
      checkOutput("fetch mem_addr", 32'(bus.mem_addr), 32'(i));
      tick();
      checkOutput("fetch f_rsp_valid", 32'(bus.f_rsp_valid), 32'd1);
      checkOutput("fetch f_rsp_data", bus.f_rsp_data, prog[i]);
      checkOutput("fetch l_rsp_valid", 32'(bus.l_rsp_valid), 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("idle mem_en", 32'(bus.mem_en), 32'd0);
    tick();
    checkOutput("idle f_rsp_valid", 32'(bus.f_rsp_valid), 32'd0);

    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    checkOutput("wr mem_we", 32'(bus.mem_we), 32'd1);
    checkOutput("wr mem_addr", 32'(bus.mem_addr), 32'd4);
    checkOutput("wr mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    checkOutput("wr l_rsp_valid", 32'(bus.l_rsp_valid), 32'd1);
    checkOutput("wr l_rsp_data", bus.l_rsp_data, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0);
    checkOutput("rd mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    checkOutput("rd l_rsp_valid", 32'(bus.l_rsp_valid), 32'd1);
    checkOutput("rd l_rsp_data", bus.l_rsp_data, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    // Continuous contention: four loader grants, then one fetch grant, repeating.
    for (int i = 0; i < 10; i++) begin
      exp_l = ((i % 5) != 4);
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'd0);
      checkOutput("arb l_req_ready", 32'(bus.l_req_ready), 32'(exp_l));
      checkOutput("arb f_req_ready", 32'(bus.f_req_ready), 32'(!exp_l));
      tick();
      checkOutput("arb l_rsp_valid", 32'(bus.l_rsp_valid), 32'(exp_l));
      checkOutput("arb f_rsp_valid", 32'(bus.f_rsp_valid), 32'(!exp_l));
      checkOutput("arb f_rsp_data", bus.f_rsp_data, exp_l ? 32'd0 : 32'h0000_0013);
      checkOutput("arb l_rsp_data", bus.l_rsp_data, exp_l ? 32'hDEAD_BEEF : 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("misaligned f_req_ready", 32'(bus.f_req_ready), 32'd1);
    checkOutput("misaligned mem_en", 32'(bus.mem_en), 32'd0);
    tick();
    checkOutput("misaligned f_rsp_valid", 32'(bus.f_rsp_valid), 32'd1);
    checkOutput("misaligned f_rsp_err", 32'(bus.f_rsp_err), 32'd1);
    checkOutput("misaligned f_rsp_data", bus.f_rsp_data, 32'd0);
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("range mem_en", 32'(bus.mem_en), 32'd0);
    tick();
    checkOutput("range f_rsp_valid", 32'(bus.f_rsp_valid), 32'd1);
    checkOutput("range f_rsp_err", 32'(bus.f_rsp_err), 32'd1);
    checkOutput("range f_rsp_data", bus.f_rsp_data, 32'd0);

    // 0x1002 would alias word 0 if the range check were missing.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h1002, 32'h1234_5678);
    checkOutput("badwr l_req_ready", 32'(bus.l_req_ready), 32'd1);
    checkOutput("badwr mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("badwr mem_en", 32'(bus.mem_en), 32'd0);
    tick();
    checkOutput("badwr l_rsp_valid", 32'(bus.l_rsp_valid), 32'd1);
    checkOutput("badwr l_rsp_err", 32'(bus.l_rsp_err), 32'd1);
    checkOutput("badwr l_rsp_data", bus.l_rsp_data, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h0, 32'd0);
    tick();
    checkOutput("readback l_rsp_err", 32'(bus.l_rsp_err), 32'd0);
    checkOutput("readback l_rsp_data", bus.l_rsp_data, 32'h0000_0013);

    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("rstfetch f_req_ready", 32'(bus.f_req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.f_req_valid = 1'b0;
    #1;
    checkIdleOutputs("inreset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("postreset f_rsp_valid", 32'(bus.f_rsp_valid), 32'd0);

    // Build the burst counter to 3, reset, then expect a full fresh burst of four.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'd0);
      checkOutput("prerst l_req_ready", 32'(bus.l_req_ready), 32'd1);
      tick();
    end
    rst = 1'b1;
    #1;
    checkOutput("cntrst l_rsp_valid", 32'(bus.l_rsp_valid), 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'd0);
      checkOutput("cntrst l_req_ready", 32'(bus.l_req_ready), 32'(i != 4));
      checkOutput("cntrst f_req_ready", 32'(bus.f_req_ready), 32'(i == 4));
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
